// File: rtl/argmax_cell_pkg.sv
// argmax_cell_pkg: shared width default and unsigned compare helper for the arg-max datapath
package argmax_cell_pkg;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int CMP_WIDTH = 64;
  function automatic logic is_greater(input logic [CMP_WIDTH-1:0] a, input logic [CMP_WIDTH-1:0] b);
    return a > b;
  endfunction
endpackage

// File: rtl/argmax_select.sv
// argmax_select: picks the incoming (value, index) on a frame restart or a strictly larger value
module argmax_select
  import argmax_cell_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  restart,
  input  logic [DATA_WIDTH-1:0] new_value,
  input  logic [DATA_WIDTH-1:0] new_index,
  input  logic [DATA_WIDTH-1:0] old_value,
  input  logic [DATA_WIDTH-1:0] old_index,
  output logic [DATA_WIDTH-1:0] sel_value,
  output logic [DATA_WIDTH-1:0] sel_index
);
  logic take;
  always_comb begin
    take = restart || is_greater(CMP_WIDTH'(new_value), CMP_WIDTH'(old_value));
    sel_value = take ? new_value : old_value;
    sel_index = take ? new_index : old_index;
  end
endmodule

// File: rtl/argmax_cell.sv
// argmax_cell: streaming arg-max over WEIGHT_AMOUNT elements, flags the winner while the last one is presented
module argmax_cell
  import argmax_cell_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int WEIGHT_AMOUNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_index,
  input  logic [DATA_WIDTH-1:0] input_value,
  input  logic                  input_enable,
  output logic [DATA_WIDTH:0]   output_result
);
  localparam logic [DATA_WIDTH-1:0] LAST = DATA_WIDTH'(WEIGHT_AMOUNT - 1);
  logic [DATA_WIDTH-1:0] max_value, max_index, cand_value, cand_index;
  logic accepted;
  assign accepted = input_enable && (input_index <= LAST);
  argmax_select #(.DATA_WIDTH(DATA_WIDTH)) u_select (
    .restart  (input_index == '0),
    .new_value(input_value),
    .new_index(input_index),
    .old_value(max_value),
    .old_index(max_index),
    .sel_value(cand_value),
    .sel_index(cand_index)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      max_value <= '0;
      max_index <= '0;
    end else if (accepted) begin
      max_value <= cand_value;
      max_index <= cand_index;
    end
  end
  assign output_result = (accepted && !rst && input_index == LAST) ? {1'b1, cand_index} : '0;
endmodule

// File: tb/tb_argmax_cell.sv
// tb_argmax_cell: directed vectors, drive on falling edge, sample just before the next rising edge
module tb_argmax_cell;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_index = '0;
  logic [31:0] input_value = '0;
  logic        input_enable = 1'b0;
  logic [32:0] output_result;
  int tests = 0;
  int fails = 0;
  argmax_cell #(.DATA_WIDTH(32), .WEIGHT_AMOUNT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_index  (input_index),
    .input_value  (input_value),
    .input_enable (input_enable),
    .output_result(output_result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic en, input logic [31:0] idx,
                      input logic [31:0] v, input logic [32:0] exp);
    @(negedge clk);
    rst = r;
    input_enable = en;
    input_index = idx;
    input_value = v;
    #4;
    check(tag, output_result, exp);
  endtask
  localparam logic [32:0] Z = 33'h0;
  localparam logic [32:0] V0 = {1'b1, 32'd0};
  localparam logic [32:0] V1 = {1'b1, 32'd1};
  initial begin
    step("rst_out",        1, 1, 1, 5, Z);
    step("rst_state",      0, 1, 1, 0, V0);
    step("dis_a",          0, 0, 0, 1, Z);
    step("dis_b",          0, 0, 1, 0, Z);
    step("basic_first",    0, 1, 0, 2, Z);
    step("basic_last",     0, 1, 1, 1, V0);
    step("later_first",    0, 1, 0, 3, Z);
    step("later_last",     0, 1, 1, 6, V1);
    step("later_dis",      0, 0, 1, 6, Z);
    step("tie_first",      0, 1, 0, 5, Z);
    step("tie_last",       0, 1, 1, 5, V0);
    step("rr_first",       0, 1, 0, 9, Z);
    step("rr_rst",         1, 0, 0, 0, Z);
    step("rr_idx0",        0, 1, 0, 1, Z);
    step("rr_last",        0, 1, 1, 0, V0);
    step("restart_a",      0, 1, 0, 9, Z);
    step("restart_b",      0, 1, 0, 1, Z);
    step("restart_last",   0, 1, 1, 4, V1);
    step("oor_first",      0, 1, 0, 1, Z);
    step("oor_idx5",       0, 1, 5, 100, Z);
    step("oor_last",       0, 1, 1, 0, V0);
    step("rstwin_first",   0, 1, 0, 9, Z);
    step("rstwin_rst",     1, 1, 0, 20, Z);
    step("rstwin_last",    0, 1, 1, 3, V1);
    step("big_first",      0, 1, 0, 32'hFFFF_FFFF, Z);
    step("big_last",       0, 1, 1, 32'hFFFF_FFFE, V0);
    step("uns_first",      0, 1, 0, 0, Z);
    step("uns_last",       0, 1, 1, 32'hFFFF_FFFF, V1);
    step("after_last",     0, 0, 1, 0, Z);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/argmax_cell.md
Name: argmax_cell

Overview:
- Streaming arg-max unit for the classifier output stage.
- Consumes one (index, value) pair per enabled clock, in index order 0..WEIGHT_AMOUNT-1.
- Tracks the running maximum value and the index where it occurs.
- During the cycle the final element is presented, it drives a valid flag plus the index of the overall maximum.

Parameters:
- DATA_WIDTH, 32, width of input_value, input_index and the index field of output_result.
- WEIGHT_AMOUNT, 2, number of elements per argmax frame (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- input_index  input  DATA_WIDTH  position of the current element within the frame.
- input_value  input  DATA_WIDTH  unsigned value of the current element.
- input_enable  input  1  current element is valid; ignored when low.
- output_result  output  DATA_WIDTH+1  bit[DATA_WIDTH] = result valid; bits[DATA_WIDTH-1:0] = argmax index.

Behaviour:
- State registers: max_value (DATA_WIDTH) and max_index (DATA_WIDTH). rst at a rising edge clears both to 0.
- Element "accepted" = input_enable=1 and input_index < WEIGHT_AMOUNT.
  - Indices >= WEIGHT_AMOUNT are ignored: no state change, output 0.
- Combinational candidate for an accepted element:
  - If input_index==0: candidate = (input_value, 0). A new frame starts; stored state is discarded.
  - Else if input_value > max_value (unsigned, strict): candidate = (input_value, input_index).
  - Else: candidate = (max_value, max_index). Ties keep the earlier index.
- Register update: on each rising edge with an accepted element and rst=0, max_value/max_index <= candidate. With no accepted element, state holds.
- Output is combinational, zero latency:
  - Accepted element with input_index==WEIGHT_AMOUNT-1: output_result = {1'b1, candidate index}.
  - All other times (including input_enable=0 or rst=1): output_result = 0, all bits.
- Output is valid only while the last element is presented; it is not held afterwards.
- WEIGHT_AMOUNT==1: every accepted index-0 element yields {1, 0}.
- Index 0 arriving mid-frame silently restarts the frame.
- Indices are not checked for ordering. A skipped index simply does not contribute.
- rst and an accepted element in the same cycle: rst wins for the registers. The output still reflects rst=1, i.e. 0.
- Values are unsigned. Equal maximum values resolve to the lowest index.

Decomposition:
- Shared package: DATA_WIDTH default constant; a helper function for the strict unsigned greater-than compare-and-select.
- One natural sub-module, argmax_select: combinational (value, index) 2-way selector with frame-restart override.
- argmax_cell keeps the registers and output logic.

Test Plan:
- Bench drives inputs on the falling edge and samples output_result just before the next rising edge.
- Idle/disabled: enable=0, (idx0,v1) then (idx1,v0) -> output_result=0 every cycle.
- Basic frame: enable=1, (idx0,v2) -> 0; (idx1,v1) -> {1,32'd0}.
- Later max wins: (idx0,v3) -> 0; (idx1,v6) enable=1 -> {1,32'd1}; same with enable=0 -> 0.
- Tie: (idx0,v5) then (idx1,v5) -> {1,32'd0}.
- Restart and reset: (idx0,v9), then rst=1 one cycle (output 0), then (idx0,v1), (idx1,v0) -> {1,0}. Also (idx0,v9), (idx0,v1), (idx1,v4) -> {1,32'd1}.
- Out-of-range: WEIGHT_AMOUNT=2, (idx0,v1), (idx5,v100), (idx1,v0) -> 0 during idx5, then {1,0}.
